// File: rtl/sector_flusher.sv
// Write-back scheduler: walks dirty sectors round-robin on a flush command,
// issues each to the storage writer with retry/timeout, then clears its dirty bit.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | waiting for flush_req
// S_SCAN      | pick next dirty sector at or after rr_ptr, or finish if clean
// S_ISSUE     | wb_valid held until the writer accepts
// S_WAIT_DONE | waiting for wb_done, bounded by the timeout counter
// S_CLEAR     | one-cycle clear of the dirty bit through the tracker port
// S_DONE      | one-cycle flush_done pulse
module sector_flusher #(
    parameter int NUM_SECTORS = 64,
    parameter int SADDR_W     = 6,
    parameter int TIMEOUT     = 1024,
    parameter int MAX_RETRY   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SECTORS-1:0] dirty_sectors,
    input  logic                   all_clean,
    input  logic                   flush_req,
    output logic                   busy,
    output logic                   flush_done,
    output logic                   flush_err,
    output logic                   wb_valid,
    output logic [SADDR_W-1:0]     wb_saddr,
    input  logic                   wb_ready,
    input  logic                   wb_done,
    input  logic                   wb_err,
    output logic                   clr_en,
    output logic [SADDR_W-1:0]     clr_saddr,
    output logic                   clr_d
);

    localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT_DONE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SADDR_W-1:0]       rr_ptr;
    logic [SADDR_W-1:0]       cur_saddr;
    logic [RETRY_W-1:0]       retry_cnt;
    logic [CNT_W-1:0]         tmo_cnt;
    logic                     flush_err_q;

    logic [2*NUM_SECTORS-1:0] doubled;
    logic [NUM_SECTORS-1:0]   rotated;
    logic [SADDR_W-1:0]       pick_off;
    logic [SADDR_W-1:0]       pick_saddr;
    logic                     pick_found;
    logic                     attempt_fail;
    logic                     retry_left;

    // Rotate the bitmap so rr_ptr lands at bit 0; the lowest set bit of the
    // rotated vector is then the first dirty sector at or after rr_ptr.
    always_comb begin
        doubled    = {dirty_sectors, dirty_sectors} >> rr_ptr;
        rotated    = doubled[NUM_SECTORS-1:0];
        pick_found = 1'b0;
        pick_off   = '0;
        for (int i = NUM_SECTORS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                pick_found = 1'b1;
                pick_off   = SADDR_W'(i);
            end
        end
        pick_saddr = rr_ptr + pick_off;
    end

    assign retry_left = (retry_cnt < RETRY_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        attempt_fail = 1'b0;
        case (state)
            S_IDLE: begin
                if (flush_req) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (all_clean || !pick_found) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wb_ready) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A completion on the expiry cycle still counts as a completion.
                if (wb_done && !wb_err) begin
                    state_nxt = S_CLEAR;
                end else if (wb_done || (tmo_cnt == CNT_LAST)) begin
                    attempt_fail = 1'b1;
                    state_nxt    = retry_left ? S_ISSUE : S_DONE;
                end
            end
            S_CLEAR: begin
                state_nxt = S_SCAN;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            cur_saddr   <= '0;
            retry_cnt   <= '0;
            tmo_cnt     <= '0;
            flush_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush_req) begin
                        flush_err_q <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (!all_clean && pick_found) begin
                        cur_saddr <= pick_saddr;
                        retry_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    if (wb_ready) begin
                        tmo_cnt <= '0;
                    end
                end
                S_WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (attempt_fail) begin
                        if (retry_left) begin
                            retry_cnt <= retry_cnt + 1'b1;
                        end else begin
                            flush_err_q <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    rr_ptr <= cur_saddr + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode straight from state so an async reset drops them at once.
    assign busy       = (state != S_IDLE);
    assign flush_done = (state == S_DONE);
    assign flush_err  = flush_err_q;
    assign wb_valid   = (state == S_ISSUE);
    assign wb_saddr   = cur_saddr;
    assign clr_en     = (state == S_CLEAR);
    assign clr_saddr  = cur_saddr;
    assign clr_d      = 1'b0;

endmodule

// File: doc/sector_flusher.md
Name: sector_flusher

Overview:
Write-back scheduler directly downstream of the dirty-sector tracker. It consumes the 64-bit dirty bitmap and all_clean flag and, on a flush command, walks the dirty sectors in round-robin order. For each one it issues a write-back request to the storage writer, waits for completion, then clears that sector's dirty bit through the tracker's write port (en/saddr/d). It reports done, or sticky error, to the controller.

Parameters:
NUM_SECTORS, 64, bitmap width; must be a power of 2.
SADDR_W, 6, log2(NUM_SECTORS).
TIMEOUT, 1024, max cycles in WAIT_DONE before a write attempt counts as failed.
MAX_RETRY, 3, retries per sector after the first failed attempt.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
dirty_sectors  in  NUM_SECTORS  live bitmap from tracker.
all_clean  in  1  tracker flag: bitmap == 0.
flush_req  in  1  one-cycle start pulse.
busy  out  1  high in any non-IDLE state.
flush_done  out  1  one-cycle pulse on flush completion (success or error).
flush_err  out  1  sticky error; cleared on the next accepted flush_req.
wb_valid  out  1  write-back request valid.
wb_saddr  out  SADDR_W  sector to write back; stable while wb_valid.
wb_ready  in  1  writer accepts request when wb_valid && wb_ready.
wb_done  in  1  one-cycle completion pulse.
wb_err  in  1  qualifies wb_done; 1 = write failed.
clr_en  out  1  tracker write enable.
clr_saddr  out  SADDR_W  tracker address.
clr_d  out  1  tracker data; tied 0.

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; retry_cnt=0; timeout counter=0. An asynchronous reset mid-operation abandons any in-flight request: wb_valid drops immediately and no clear is issued.
- States: IDLE, SCAN, ISSUE, WAIT_DONE, CLEAR, DONE.
- IDLE:
  - flush_req=1 -> clear flush_err, go to SCAN.
  - flush_req is ignored in every other state.
- SCAN (1 cycle):
  - all_clean=1 -> DONE.
  - Otherwise select the first set bit of dirty_sectors at index >= rr_ptr, wrapping modulo NUM_SECTORS. Register it into cur_saddr, reset retry_cnt, go to ISSUE.
  - Sectors dirtied during a flush are picked up by later scans. The flush ends only when all_clean is seen in SCAN.
- ISSUE:
  - wb_valid=1, wb_saddr=cur_saddr.
  - On wb_valid && wb_ready -> WAIT_DONE. The handshake cycle is the last cycle wb_valid is high.
  - No timeout applies in ISSUE.
- WAIT_DONE:
  - The timeout counter increments each cycle.
  - wb_done && !wb_err -> CLEAR.
  - wb_done && wb_err, or counter reaches TIMEOUT-1 without wb_done -> failed attempt:
    - retry_cnt < MAX_RETRY: increment retry_cnt, go to ISSUE (same sector).
    - otherwise: set flush_err, go to DONE; the dirty bit stays set.
  - The counter clears on entry to WAIT_DONE.
  - A wb_done arriving in the same cycle as timeout expiry counts as the completion (done wins).
- CLEAR (1 cycle):
  - clr_en=1, clr_saddr=cur_saddr, clr_d=0.
  - rr_ptr <= cur_saddr+1, wrapping from NUM_SECTORS-1 to 0.
  - Next state SCAN. The tracker updates on this edge, so SCAN sees the cleared bitmap and never re-picks the same sector.
- DONE: flush_done=1 for one cycle -> IDLE.
- clr_en is asserted only in CLEAR; clr_d is always 0.
- busy = (state != IDLE).
- Per-sector overhead: 1 SCAN + at least 1 ISSUE + at least 1 WAIT_DONE + 1 CLEAR cycles.
- A flush_req when the bitmap is already clean gives IDLE->SCAN->DONE; flush_done pulses 2 cycles after flush_req.

Test Plan:
- Clean flush: bitmap=0, all_clean=1, flush_req pulse -> no wb_valid; flush_done pulses exactly 2 cycles later; flush_err=0.
- Ordered walk: bitmap=0x8000_0000_0000_0009, writer always ready, wb_done 2 cycles after accept -> wb_saddr sequence 0, 3, 63 -> clr_en pulses with clr_saddr 0, 3, 63 and clr_d=0 -> flush_done pulse, tracker bitmap=0.
- Round-robin wrap / late dirty: during the flush of sector 3, set bit 1 and bit 10 -> next issued are 10 then 1 -> flush completes with bitmap=0.
- Retry then success: wb_err=1 on the first 2 completions for sector 5 -> 3 handshakes on wb_saddr=5, then clr_en for 5, flush_err=0.
- Timeout exhaustion: TIMEOUT=16, MAX_RETRY=3, wb_done never arrives -> 4 requests for the sector, flush_err=1, flush_done pulse, bit still set. A new flush_req clears flush_err.
- Reset mid-WAIT_DONE: assert reset -> busy, wb_valid and clr_en go to 0 without waiting for a clock edge; bitmap unchanged; rr_ptr=0 after release.
